// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, shift L/R, load, clear, set, with a saturating shift counter and done pulse.
// Build option: define ROTATE_EN to turn modes 110/111 into rotates; otherwise they hold.
module shift_reg_univ #(
   parameter int unsigned     WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       en,
   input  logic [2:0]                 mode,
   input  logic [WIDTH-1:0]           d,
   input  logic                       sin_l,
   input  logic                       sin_r,
   output logic [WIDTH-1:0]           q,
   output logic [WIDTH-1:0]           qbar,
   output logic                       sout_msb,
   output logic                       sout_lsb,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_CLR  = 3'b100;
   localparam logic [2:0] MODE_SET  = 3'b101;
   localparam logic [2:0] MODE_ROTL = 3'b110;
   localparam logic [2:0] MODE_ROTR = 3'b111;

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_shift;
   logic             w_cnt_clr;

   // Next-value select; every path is built from registered q only.
   always_comb begin
      w_q_nxt   = r_q;
      w_shift   = 1'b0;
      w_cnt_clr = 1'b0;
      case (mode)
         MODE_HOLD: w_q_nxt = r_q;
         MODE_SHL: begin
            w_q_nxt = {r_q[WIDTH-2:0], sin_r};
            w_shift = 1'b1;
         end
         MODE_SHR: begin
            w_q_nxt = {sin_l, r_q[WIDTH-1:1]};
            w_shift = 1'b1;
         end
         MODE_LOAD: begin
            w_q_nxt   = d;
            w_cnt_clr = 1'b1;
         end
         MODE_CLR: begin
            w_q_nxt   = '0;
            w_cnt_clr = 1'b1;
         end
         MODE_SET: begin
            w_q_nxt   = '1;
            w_cnt_clr = 1'b1;
         end
`ifdef ROTATE_EN
         MODE_ROTL: begin
            w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_shift = 1'b1;
         end
         MODE_ROTR: begin
            w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            w_shift = 1'b1;
         end
`else
         MODE_ROTL, MODE_ROTR: w_q_nxt = r_q;
`endif
         default: w_q_nxt = r_q;
      endcase
   end

   // State update; done marks the shift that completes a full word.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_q    <= RESET_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (!en) begin
         r_done <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_done <= w_shift && (r_cnt == CW'(WIDTH - 1));
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_shift && (r_cnt != CW'(WIDTH)))
            r_cnt <= r_cnt + CW'(1);
      end
   end

   assign q        = r_q;
   assign qbar     = ~r_q;
   assign sout_msb = r_q[WIDTH-1];
   assign sout_lsb = r_q[0];
   assign cnt      = r_cnt;
   assign done     = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus randomized traffic against an arithmetic model.
module tb_shift_reg_univ;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_l;
   logic       sin_r;

   logic [7:0] q0, qbar0, q1, qbar1;
   logic       msb0, lsb0, msb1, lsb1, done0, done1;
   logic [3:0] cnt0, cnt1;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: two register images (different reset values), shared count and done.
   int m_q [2];
   int m_cnt;
   int m_done;

   always #5 clk = ~clk;

   shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut0 (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(q0), .qbar(qbar0), .sout_msb(msb0), .sout_lsb(lsb0), .cnt(cnt0), .done(done0));

   shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut1 (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(q1), .qbar(qbar1), .sout_msb(msb1), .sout_lsb(lsb1), .cnt(cnt1), .done(done1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int next_q(input int qv, input int m, input int dv, input int sl, input int sr);
      case (m)
         1: return (qv * 2 + sr) % 256;
         2: return qv / 2 + sl * 128;
         3: return dv;
         4: return 0;
         5: return 255;
`ifdef ROTATE_EN
         6: return (qv * 2 + qv / 128) % 256;
         7: return qv / 2 + (qv % 2) * 128;
`endif
         default: return qv;
      endcase
   endfunction

   function automatic bit is_shift(input int m);
`ifdef ROTATE_EN
      return (m == 1) || (m == 2) || (m == 6) || (m == 7);
`else
      return (m == 1) || (m == 2);
`endif
   endfunction

   task automatic model_step();
      if (!rstn) begin
         m_q[0] = 0; m_q[1] = 'hA5; m_cnt = 0; m_done = 0;
      end else if (!en) begin
         m_done = 0;
      end else begin
         for (int k = 0; k < 2; k++)
            m_q[k] = next_q(m_q[k], int'(mode), int'(d), int'(sin_l), int'(sin_r));
         if (is_shift(int'(mode))) begin
            m_done = (m_cnt == 7) ? 1 : 0;
            if (m_cnt < 8) m_cnt++;
         end else begin
            m_done = 0;
            if (mode inside {3'd3, 3'd4, 3'd5}) m_cnt = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("q0",    32'(q0),    32'(m_q[0]));
      chk("qbar0", 32'(qbar0), 32'(255 - m_q[0]));
      chk("msb0",  32'(msb0),  32'(m_q[0] / 128));
      chk("lsb0",  32'(lsb0),  32'(m_q[0] % 2));
      chk("cnt0",  32'(cnt0),  32'(m_cnt));
      chk("done0", 32'(done0), 32'(m_done));
      chk("q1",    32'(q1),    32'(m_q[1]));
      chk("qbar1", 32'(qbar1), 32'(255 - m_q[1]));
      chk("cnt1",  32'(cnt1),  32'(m_cnt));
      chk("done1", 32'(done1), 32'(m_done));
   endtask

   // Apply one cycle of inputs, advance the model at the edge, compare just after it.
   task automatic step(input logic rn, input logic e, input logic [2:0] m,
                       input logic [7:0] dv, input logic sl, input logic sr);
      rstn = rn; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] bits_in;
      logic [7:0] msb_seq;
      rstn = 1'b0; en = 1'b1; mode = 3'b011; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;
      m_q[0] = 0; m_q[1] = 0; m_cnt = 0; m_done = 0;

      // Reset dominates enable and a pending load.
      step(1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
      step(1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
      chk("rst_q",    32'(q0),    32'h00);
      chk("rst_qbar", 32'(qbar0), 32'hFF);
      chk("rst_cnt",  32'(cnt0),  32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_q_a5", 32'(q1),    32'hA5);

      // Serializer: MSB-first readout of 8'hB4.
      step(1'b1, 1'b1, 3'b011, 8'hB4, 1'b0, 1'b0);
      msb_seq = '0;
      for (int i = 0; i < 8; i++) begin
         msb_seq = {msb_seq[6:0], msb0};
         step(1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
         chk("ser_done", 32'(done0), (i == 7) ? 32'd1 : 32'd0);
      end
      chk("ser_seq",  32'(msb_seq), 32'hB4);
      chk("ser_q",    32'(q0),      32'h00);
      chk("ser_cnt",  32'(cnt0),    32'd8);
      step(1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
      chk("sat_cnt",  32'(cnt0),    32'd8);
      chk("sat_done", 32'(done0),   32'd0);

      // Deserializer: CLR then shift 1,1,0,0,1,0,1,0 in from the MSB side.
      bits_in = 8'b1100_1010;
      step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 3'b010, 8'h00, bits_in[7-i], 1'b0);
         chk("des_done", 32'(done0), (i == 7) ? 32'd1 : 32'd0);
      end
      chk("des_q", 32'(q0), 32'h53);

      // Enable gating freezes q and cnt.
      step(1'b1, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b001, 8'h00, 1'b0, 1'b1);
      chk("en_q",   32'(q0),   32'h3C);
      chk("en_cnt", 32'(cnt0), 32'd0);
      step(1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1);
      chk("en_shl", 32'(q0), 32'h79);

      // Reset in the middle of a word discards the partial count.
      step(1'b1, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
      chk("mid_q",   32'(q0),   32'h00);
      chk("mid_cnt", 32'(cnt0), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
         chk("mid_done", 32'(done0), (i == 7) ? 32'd1 : 32'd0);
      end

      // Rotate modes (hold when rotation is not built in).
      step(1'b1, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
      step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
`ifdef ROTATE_EN
      chk("rotl", 32'(q0), 32'h03);
`else
      chk("rotl", 32'(q0), 32'h81);
      chk("rotl_cnt", 32'(cnt0), 32'd0);
`endif
      step(1'b1, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
      step(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
`ifdef ROTATE_EN
      chk("rotr", 32'(q0), 32'hC0);
`else
      chk("rotr", 32'(q0), 32'h81);
      chk("rotr_cnt", 32'(cnt0), 32'd0);
`endif

      // Random traffic, shift-heavy so the counter saturates and done fires often.
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] rm;
         rm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), rm,
              8'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
